// File: rtl/ddr_port_arbiter.sv
// Round-robin arbiter sharing one DDR3 user port between instruction fetch and the Memory stage.
// One single-beat transaction in flight at a time; a read that never returns is retired by a timeout.
//
// state | meaning
// IDLE  | no transaction; grants are only issued here
// CMD   | command presented to DDR, held until accepted
// WDATA | store beat presented to DDR, held until accepted
// RWAIT | waiting for the read beat, bounded by the read timer
module ddr_port_arbiter #(
    parameter int ADDR_W     = 29,
    parameter int DATA_W     = 32,
    parameter int RD_TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req_i,
    input  logic [ADDR_W-1:0] fetch_addr_i,
    output logic              fetch_gnt_o,
    output logic [DATA_W-1:0] fetch_rdata_o,
    output logic              fetch_rvalid_o,
    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic              data_gnt_o,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              data_rvalid_o,
    output logic              data_wdone_o,
    output logic              timeout_o,
    output logic              memory_enable_o,
    output logic              memory_cmd_o,
    output logic [ADDR_W-1:0] memory_address_o,
    input  logic              memory_cmd_rdy_i,
    output logic              memory_write_enable_o,
    output logic [DATA_W-1:0] memory_write_data_o,
    output logic              memory_write_data_end_o,
    input  logic              memory_write_rdy_i,
    input  logic [DATA_W-1:0] memory_read_data_i,
    input  logic              memory_read_data_valid_i,
    input  logic              memory_read_data_end_i
);
    localparam int TW = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_WDATA, S_RWAIT} state_t;

    state_t            state_q, state_d;
    logic              last_data_q, last_data_d;
    logic              own_data_q, own_data_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              beat_q, beat_d;
    logic              fetch_gnt_q, fetch_gnt_d, data_gnt_q, data_gnt_d;
    logic              fetch_rvalid_q, fetch_rvalid_d, data_rvalid_q, data_rvalid_d;
    logic [DATA_W-1:0] fetch_rdata_q, fetch_rdata_d, data_rdata_q, data_rdata_d;
    logic              wdone_q, wdone_d, timeout_q, timeout_d;
    logic              pick_data;
    logic              ret_valid;
    logic [DATA_W-1:0] ret_data;

    always_comb begin
        state_d        = state_q;
        last_data_d    = last_data_q;
        own_data_d     = own_data_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        timer_d        = timer_q;
        beat_d         = beat_q;
        fetch_rdata_d  = fetch_rdata_q;
        data_rdata_d   = data_rdata_q;
        fetch_gnt_d    = 1'b0;
        data_gnt_d     = 1'b0;
        fetch_rvalid_d = 1'b0;
        data_rvalid_d  = 1'b0;
        wdone_d        = 1'b0;
        timeout_d      = 1'b0;
        pick_data      = 1'b0;
        ret_valid      = 1'b0;
        ret_data       = '0;

        unique case (state_q)
            S_IDLE: begin
                if (fetch_req_i || data_req_i) begin
                    // On a tie the requester that did not own the last grant wins
                    pick_data   = data_req_i && !(fetch_req_i && last_data_q);
                    own_data_d  = pick_data;
                    last_data_d = pick_data;
                    data_gnt_d  = pick_data;
                    fetch_gnt_d = !pick_data;
                    we_d        = pick_data && data_we_i;
                    addr_d      = pick_data ? data_addr_i : fetch_addr_i;
                    wdata_d     = pick_data ? data_wdata_i : wdata_q;
                    state_d     = S_CMD;
                end
            end
            S_CMD: begin
                if (memory_cmd_rdy_i) begin
                    if (we_q) begin
                        state_d = S_WDATA;
                    end else begin
                        state_d = S_RWAIT;
                        timer_d = TW'(RD_TIMEOUT - 1);
                        beat_d  = 1'b0;
                    end
                end
            end
            S_WDATA: begin
                if (memory_write_rdy_i) begin
                    wdone_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_RWAIT: begin
                if (memory_read_data_valid_i) begin
                    if (!beat_q) begin
                        beat_d    = 1'b1;
                        ret_valid = 1'b1;
                        ret_data  = memory_read_data_i;
                    end
                    if (memory_read_data_end_i) state_d = S_IDLE;
                end else if (!beat_q && timer_q == '0) begin
                    timeout_d = 1'b1;
                    ret_valid = 1'b1;
                    state_d   = S_IDLE;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (ret_valid) begin
            if (own_data_q) begin
                data_rvalid_d = 1'b1;
                data_rdata_d  = ret_data;
            end else begin
                fetch_rvalid_d = 1'b1;
                fetch_rdata_d  = ret_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            last_data_q    <= 1'b0;
            own_data_q     <= 1'b0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            timer_q        <= '0;
            beat_q         <= 1'b0;
            fetch_gnt_q    <= 1'b0;
            data_gnt_q     <= 1'b0;
            fetch_rvalid_q <= 1'b0;
            data_rvalid_q  <= 1'b0;
            fetch_rdata_q  <= '0;
            data_rdata_q   <= '0;
            wdone_q        <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_data_q    <= last_data_d;
            own_data_q     <= own_data_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            timer_q        <= timer_d;
            beat_q         <= beat_d;
            fetch_gnt_q    <= fetch_gnt_d;
            data_gnt_q     <= data_gnt_d;
            fetch_rvalid_q <= fetch_rvalid_d;
            data_rvalid_q  <= data_rvalid_d;
            fetch_rdata_q  <= fetch_rdata_d;
            data_rdata_q   <= data_rdata_d;
            wdone_q        <= wdone_d;
            timeout_q      <= timeout_d;
        end
    end

    assign fetch_gnt_o    = fetch_gnt_q;
    assign data_gnt_o     = data_gnt_q;
    assign fetch_rvalid_o = fetch_rvalid_q;
    assign data_rvalid_o  = data_rvalid_q;
    assign fetch_rdata_o  = fetch_rdata_q;
    assign data_rdata_o   = data_rdata_q;
    assign data_wdone_o   = wdone_q;
    assign timeout_o      = timeout_q;

    // DDR side decodes straight from the state register so reset drops it immediately
    assign memory_enable_o         = (state_q == S_CMD);
    assign memory_cmd_o            = (state_q == S_CMD) && !we_q;
    assign memory_address_o        = addr_q;
    assign memory_write_enable_o   = (state_q == S_WDATA);
    assign memory_write_data_end_o = (state_q == S_WDATA);
    assign memory_write_data_o     = wdata_q;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Randomized bench for ddr_port_arbiter: the bench plays both requesters and the DDR port,
// predicting grant order, bus activity and returned data from the arbitration rules.
module tb_ddr_port_arbiter;
    localparam int AW  = 29;
    localparam int DW  = 32;
    localparam int RDT = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fetch_req = 1'b0, data_req = 1'b0, data_we = 1'b0;
    logic [AW-1:0] fetch_addr = '0, data_addr = '0;
    logic [DW-1:0] data_wdata = '0;
    logic          cmd_rdy = 1'b0, wr_rdy = 1'b0, rd_valid = 1'b0, rd_end = 1'b0;
    logic [DW-1:0] rd_data = '0;

    logic          fetch_gnt_o, fetch_rvalid_o, data_gnt_o, data_rvalid_o, data_wdone_o, timeout_o;
    logic [DW-1:0] fetch_rdata_o, data_rdata_o, memory_write_data_o;
    logic          memory_enable_o, memory_cmd_o, memory_write_enable_o, memory_write_data_end_o;
    logic [AW-1:0] memory_address_o;

    int            n_tests = 0;
    int            n_fail  = 0;
    bit            last_data_m = 1'b0;
    logic [DW-1:0] exp_frd = '0, exp_drd = '0;

    always #5 clk = ~clk;

    ddr_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_TIMEOUT(RDT)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_gnt_o(fetch_gnt_o),
        .fetch_rdata_o(fetch_rdata_o), .fetch_rvalid_o(fetch_rvalid_o),
        .data_req_i(data_req), .data_we_i(data_we), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .data_gnt_o(data_gnt_o), .data_rdata_o(data_rdata_o),
        .data_rvalid_o(data_rvalid_o), .data_wdone_o(data_wdone_o), .timeout_o(timeout_o),
        .memory_enable_o(memory_enable_o), .memory_cmd_o(memory_cmd_o),
        .memory_address_o(memory_address_o), .memory_cmd_rdy_i(cmd_rdy),
        .memory_write_enable_o(memory_write_enable_o), .memory_write_data_o(memory_write_data_o),
        .memory_write_data_end_o(memory_write_data_end_o), .memory_write_rdy_i(wr_rdy),
        .memory_read_data_i(rd_data), .memory_read_data_valid_i(rd_valid),
        .memory_read_data_end_i(rd_end)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk_rdata();
        check("rdata_fetch", 64'(fetch_rdata_o), 64'(exp_frd));
        check("rdata_data", 64'(data_rdata_o), 64'(exp_drd));
    endtask

    task automatic chk_no_rvalid(input string tag);
        check(tag, 64'({fetch_rvalid_o, data_rvalid_o, timeout_o}), 64'd0);
    endtask

    // rmode: 0 single valid+end beat, 1 valid then valid+end, 2 no beat (timeout)
    task automatic run_txn(input bit want_f, input bit want_d, input bit d_we,
                           input logic [AW-1:0] d_addr, input logic [DW-1:0] d_wdata,
                           input int cd, input int wd, input int rmode, input int rdl,
                           input logic [DW-1:0] rv1, input logic [DW-1:0] rv2,
                           output bit obs_data);
        bit            win_d;
        bit            e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        if (want_f && !fetch_req) begin fetch_req = 1'b1; fetch_addr = AW'($urandom); end
        if (want_d && !data_req) begin
            data_req = 1'b1; data_we = d_we; data_addr = d_addr; data_wdata = d_wdata;
        end
        if (!fetch_req && !data_req) begin fetch_req = 1'b1; fetch_addr = AW'($urandom); end
        if (fetch_req && data_req) win_d = !last_data_m;
        else win_d = data_req;
        last_data_m = win_d;
        e_we   = win_d && data_we;
        e_addr = win_d ? data_addr : fetch_addr;
        e_wd   = data_wdata;
        cyc();
        obs_data = data_gnt_o;
        check("gnt_fetch", 64'(fetch_gnt_o), 64'(!win_d));
        check("gnt_data", 64'(data_gnt_o), 64'(win_d));
        chk_no_rvalid("rvalid_at_gnt");
        check("wdone_at_gnt", 64'(data_wdone_o), 64'd0);
        chk_rdata();
        rd_valid = 1'b0; rd_end = 1'b0;
        if (win_d) data_req = 1'b0; else fetch_req = 1'b0;

        for (int i = 0; i <= cd; i++) begin
            check("cmd_en", 64'(memory_enable_o), 64'd1);
            check("cmd_rw", 64'(memory_cmd_o), 64'(!e_we));
            check("cmd_addr", 64'(memory_address_o), 64'(e_addr));
            check("cmd_wr_en", 64'(memory_write_enable_o), 64'd0);
            if (i > 0) check("gnt_one_cycle", 64'({fetch_gnt_o, data_gnt_o}), 64'd0);
            cmd_rdy = (i == cd);
            cyc();
        end
        cmd_rdy = 1'b0;
        check("cmd_en_drop", 64'(memory_enable_o), 64'd0);
        check("gnt_quiet", 64'({fetch_gnt_o, data_gnt_o}), 64'd0);

        if (e_we) begin
            for (int j = 0; j <= wd; j++) begin
                check("wr_en", 64'(memory_write_enable_o), 64'd1);
                check("wr_data", 64'(memory_write_data_o), 64'(e_wd));
                check("wr_end", 64'(memory_write_data_end_o), 64'd1);
                check("wdone_early", 64'(data_wdone_o), 64'd0);
                wr_rdy = (j == wd);
                cyc();
            end
            wr_rdy = 1'b0;
            check("wdone", 64'(data_wdone_o), 64'd1);
            check("wr_en_drop", 64'(memory_write_enable_o), 64'd0);
            chk_no_rvalid("rvalid_on_store");
        end else if (rmode == 2) begin
            for (int j = 0; j < RDT; j++) begin
                chk_no_rvalid("rvalid_before_timeout");
                cyc();
            end
            check("timeout", 64'(timeout_o), 64'd1);
            check("to_rvalid_fetch", 64'(fetch_rvalid_o), 64'(!win_d));
            check("to_rvalid_data", 64'(data_rvalid_o), 64'(win_d));
            if (win_d) exp_drd = '0; else exp_frd = '0;
            chk_rdata();
            // Late beat arriving in IDLE must be dropped; checked at the next grant
            rd_valid = 1'b1; rd_end = 1'b1; rd_data = $urandom;
        end else begin
            for (int j = 0; j <= rdl; j++) begin
                chk_no_rvalid("rvalid_early");
                rd_valid = (j == rdl);
                rd_end   = (j == rdl) && (rmode == 0);
                rd_data  = (j == rdl) ? rv1 : $urandom;
                cyc();
            end
            rd_valid = 1'b0; rd_end = 1'b0;
            if (win_d) exp_drd = rv1; else exp_frd = rv1;
            check("rvalid_fetch", 64'(fetch_rvalid_o), 64'(!win_d));
            check("rvalid_data", 64'(data_rvalid_o), 64'(win_d));
            check("timeout_quiet", 64'(timeout_o), 64'd0);
            chk_rdata();
            if (rmode == 1) begin
                for (int j = 0; j < 3; j++) begin
                    rd_valid = (j >= 1);
                    rd_end   = (j == 2);
                    rd_data  = rv2;
                    cyc();
                    chk_no_rvalid("extra_beat_ignored");
                    chk_rdata();
                end
                rd_valid = 1'b0; rd_end = 1'b0;
            end
        end
    endtask

    initial begin
        bit obs;
        logic [3:0] rr_exp;
        rr_exp = 4'b1010;
        cyc(); cyc();
        check("rst_pulses", 64'({fetch_gnt_o, data_gnt_o, fetch_rvalid_o, data_rvalid_o,
                                  data_wdone_o, timeout_o}), 64'd0);
        check("rst_ddr", 64'({memory_enable_o, memory_cmd_o, memory_write_enable_o,
                               memory_write_data_end_o}), 64'd0);
        check("rst_addr", 64'(memory_address_o), 64'd0);
        check("rst_wdata", 64'(memory_write_data_o), 64'd0);
        chk_rdata();
        rst_n = 1'b1;
        cyc();

        // Both requesters continuously pending: DATA, FETCH, DATA, FETCH
        for (int i = 0; i < 4; i++) begin
            run_txn(1'b1, 1'b1, 1'($urandom), AW'($urandom), $urandom, 0, 0, 0, 1,
                    $urandom, $urandom, obs);
            check("rr_order", 64'(obs), 64'(rr_exp[3-i]));
        end
        run_txn(1'b0, 1'b0, 1'b0, '0, '0, 0, 0, 0, 0, $urandom, $urandom, obs);

        // Store with rdy tied high
        run_txn(1'b0, 1'b1, 1'b1, AW'(29'h0000100), 32'hDEADBEEF, 0, 0, 0, 0, '0, '0, obs);
        // Load, command held off 4 cycles, beat arrives 6 cycles later
        run_txn(1'b0, 1'b1, 1'b0, AW'($urandom), '0, 4, 0, 0, 6, 32'h12345678, '0, obs);
        // Lost fetch read, then a follow-up request
        run_txn(1'b1, 1'b0, 1'b0, '0, '0, 0, 0, 2, 0, '0, '0, obs);
        run_txn(1'b1, 1'b0, 1'b0, '0, '0, 1, 0, 0, 2, $urandom, '0, obs);
        // Multi-beat read: only the first beat forwarded
        run_txn(1'b0, 1'b1, 1'b0, AW'($urandom), '0, 0, 0, 1, 1, 32'hA5A5_0001, 32'h5A5A_0002, obs);

        for (int n = 0; n < 150; n++) begin
            int m;
            m = int'($urandom_range(0, 9));
            run_txn(1'($urandom), 1'($urandom), 1'($urandom), AW'($urandom), $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                    (m < 6) ? 0 : ((m < 9) ? 1 : 2), int'($urandom_range(0, 6)),
                    $urandom, $urandom, obs);
        end

        // Asynchronous reset in the middle of a command
        cmd_rdy = 1'b0; rd_valid = 1'b0; rd_end = 1'b0;
        if (!fetch_req && !data_req) begin data_req = 1'b1; data_we = 1'b0; end
        cyc();
        check("pre_rst_cmd_en", 64'(memory_enable_o), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_en", 64'(memory_enable_o), 64'd0);
        check("async_rst_pulses", 64'({fetch_gnt_o, data_gnt_o, fetch_rvalid_o, data_rvalid_o,
                                        data_wdone_o, timeout_o}), 64'd0);
        fetch_req = 1'b0; data_req = 1'b0;
        last_data_m = 1'b0; exp_frd = '0; exp_drd = '0;
        chk_rdata();
        cyc();
        rst_n = 1'b1;
        cyc();
        check("post_rst_idle", 64'({memory_enable_o, fetch_gnt_o, data_gnt_o,
                                     fetch_rvalid_o, data_rvalid_o}), 64'd0);
        for (int i = 0; i < 2; i++) begin
            run_txn(1'b1, 1'b1, 1'b0, AW'($urandom), $urandom, 0, 0, 0, 0,
                    $urandom, $urandom, obs);
            check("post_rst_rr", 64'(obs), 64'(rr_exp[3-i]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
